mem_access: RTL

- Memory-access stage of the RISC-V core; consumes execute-stage results (ALU address, store value, alucode, destination register).
- Drives the data-memory request/acknowledge interface with byte enables, lane steering and load sign/zero extension.
- Produces a registered write-back bundle and stalls the pipeline while a memory transaction is outstanding.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: request/ack sequencing with timeout, byte lanes, load extension.
// Defining MEM_MISALIGN_TRAP_EN adds a misaligned-access trap (mem_misalign, mem_fault_addr).
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic [5:0]   ex_alucode,
  input  logic         ex_is_load,
  input  logic         ex_is_store,
  input  logic         ex_reg_we,
  input  logic [4:0]   ex_dstreg_num,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  ex_store_value,
  output logic         mem_stall,
  mem_access_if.master dmem,
  output logic         wb_valid,
  output logic         wb_we,
  output logic [4:0]   wb_dstreg_num,
  output logic [31:0]  wb_value,
  output logic         mem_fault
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic         mem_misalign,
  output logic [31:0]  mem_fault_addr
`endif
);

  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [5:0]  alucode_q, alucode_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_load_q, is_load_d, reg_we_q, reg_we_d;
  logic [4:0]  dst_q, dst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, fault_q, fault_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_value_q, wb_value_d;

  logic        mem_op, trap, trap_take;
  logic [3:0]  be_req;
  logic [31:0] wdata_req, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op    = ex_is_load | ex_is_store;
  assign trap_take = (state_q == IDLE) & ex_valid & mem_op & trap;

  always_comb begin
    be_req    = 4'b1111;
    wdata_req = ex_store_value;
    case (ex_alucode)
      ALU_LB, ALU_LBU, ALU_SB: begin
        be_req    = 4'b0001 << alu_result[1:0];
        wdata_req = {4{ex_store_value[7:0]}};
      end
      ALU_LH, ALU_LHU, ALU_SH: begin
        be_req    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_req = {2{ex_store_value[15:0]}};
      end
      ALU_LW, ALU_SW: begin
        be_req    = 4'b1111;
        wdata_req = ex_store_value;
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    case (ex_alucode)
      ALU_LH, ALU_LHU, ALU_SH: trap = alu_result[0];
      ALU_LW, ALU_SW:          trap = |alu_result[1:0];
      default: ;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  assign ld_byte = dmem.dmem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    case (alucode_q)
      ALU_LB:  load_val = {{24{ld_byte[7]}}, ld_byte};
      ALU_LBU: load_val = {24'd0, ld_byte};
      ALU_LH:  load_val = {{16{ld_half[15]}}, ld_half};
      ALU_LHU: load_val = {16'd0, ld_half};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    alucode_d  = alucode_q;
    lane_d     = lane_q;
    is_load_d  = is_load_q;
    reg_we_d   = reg_we_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_dst_d   = '0;
    wb_value_d = '0;
    fault_d    = 1'b0;
    mem_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && !mem_op) begin
          wb_valid_d = 1'b1;
          wb_we_d    = ex_reg_we;
          wb_dst_d   = ex_dstreg_num;
          wb_value_d = alu_result;
        end else if (trap_take) begin
          wb_valid_d = 1'b1;
          wb_dst_d   = ex_dstreg_num;
        end else if (ex_valid) begin
          mem_stall = 1'b1;
          state_d   = REQ;
          req_d     = 1'b1;
          we_d      = ex_is_store;
          addr_d    = {alu_result[31:2], 2'b00};
          be_d      = be_req;
          wdata_d   = wdata_req;
          alucode_d = ex_alucode;
          lane_d    = alu_result[1:0];
          is_load_d = ex_is_load;
          reg_we_d  = ex_reg_we;
          dst_d     = ex_dstreg_num;
          cnt_d     = '0;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a timeout expiring in the same cycle.
        if (dmem.dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = is_load_q & reg_we_q;
          wb_dst_d   = dst_q;
          wb_value_d = is_load_q ? load_val : '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_dst_d   = dst_q;
          fault_d    = 1'b1;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      alucode_q  <= '0;
      lane_q     <= '0;
      is_load_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      dst_q      <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_dst_q   <= '0;
      wb_value_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      alucode_q  <= alucode_d;
      lane_q     <= lane_d;
      is_load_q  <= is_load_d;
      reg_we_q   <= reg_we_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_dst_q   <= wb_dst_d;
      wb_value_q <= wb_value_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_we           = wb_we_q;
  assign wb_dstreg_num   = wb_dst_q;
  assign wb_value        = wb_value_q;
  assign mem_fault       = fault_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  always_comb begin
    misalign_d   = trap_take;
    fault_addr_d = trap_take ? alu_result : fault_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign mem_misalign   = misalign_q;
  assign mem_fault_addr = fault_addr_q;
`endif

endmodule
